// File: rtl/logic_axi4_stream_packet_generator_if.sv
// AXI4-Stream transmit bundle driven by the packet generator.
// The master side drives every tx_* signal. The slave side returns only tx_tready.
interface logic_axi4_stream_packet_generator_if #(
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic                       tx_tvalid;
  logic                       tx_tready;
  logic                       tx_tlast;
  logic [TDATA_BYTES*8-1:0]   tx_tdata;
  logic [TDATA_BYTES-1:0]     tx_tkeep;
  logic [TDATA_BYTES-1:0]     tx_tstrb;
  logic [TDEST_WIDTH-1:0]     tx_tdest;
  logic [TUSER_WIDTH-1:0]     tx_tuser;
  logic [TID_WIDTH-1:0]       tx_tid;

  modport master (
    output tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tstrb, tx_tdest, tx_tuser, tx_tid,
    input  tx_tready
  );

  modport slave (
    input  tx_tvalid, tx_tlast, tx_tdata, tx_tkeep, tx_tstrb, tx_tdest, tx_tuser, tx_tid,
    output tx_tready
  );
endinterface

// File: rtl/logic_axi4_stream_packet_generator.sv
// AXI4-Stream packet source. It turns a (length, seed, sideband) command into one packet.
// The payload is an incrementing byte pattern. The last beat carries a partial tkeep/tstrb.
module logic_axi4_stream_packet_generator #(
  parameter int TDATA_BYTES  = 4,
  parameter int TDEST_WIDTH  = 1,
  parameter int TUSER_WIDTH  = 1,
  parameter int TID_WIDTH    = 1,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LENGTH_WIDTH-1:0] cmd_length,
  input  logic [7:0]              cmd_seed,
  input  logic [TDEST_WIDTH-1:0]  cmd_tdest,
  input  logic [TID_WIDTH-1:0]    cmd_tid,
  input  logic [TUSER_WIDTH-1:0]  cmd_tuser,
  logic_axi4_stream_packet_generator_if.master tx,
  output logic                    busy,
  output logic [31:0]             packet_count
);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [LENGTH_WIDTH:0]   BEAT_BYTES = (LENGTH_WIDTH+1)'(TDATA_BYTES);
  localparam logic [LENGTH_WIDTH-1:0] BEAT_LEN   = LENGTH_WIDTH'(TDATA_BYTES);
  localparam logic [7:0]              BASE_STEP  = 8'(TDATA_BYTES);

  state_t                   state_q, state_d;
  logic [LENGTH_WIDTH-1:0]  rem_q, rem_d;
  logic [7:0]               base_q, base_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic [TDATA_BYTES*8-1:0] tdata_q, tdata_d;
  logic [TDATA_BYTES-1:0]   tkeep_q, tkeep_d;
  logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
  logic [TUSER_WIDTH-1:0]   tuser_q, tuser_d;
  logic [TID_WIDTH-1:0]     tid_q, tid_d;
  logic                     busy_q, busy_d;
  logic [31:0]              count_q, count_d;

  logic                     load;
  logic [LENGTH_WIDTH-1:0]  load_rem;
  logic [7:0]               load_base;
  logic [LENGTH_WIDTH:0]    load_rem_x;
  logic                     beat_last;
  logic [TDATA_BYTES-1:0]   beat_keep;
  logic [TDATA_BYTES*8-1:0] beat_data;

  // A beat is loaded either from a fresh command or after a non-last handshake.
  // The subtraction only happens when remaining > TDATA_BYTES, so it cannot underflow.
  always_comb begin
    load      = 1'b0;
    load_rem  = rem_q;
    load_base = base_q;
    if (state_q == IDLE) begin
      if (cmd_valid && (cmd_length != '0)) begin
        load      = 1'b1;
        load_rem  = cmd_length;
        load_base = cmd_seed;
      end
    end else if (tvalid_q && tx.tx_tready && !tlast_q) begin
      load      = 1'b1;
      load_rem  = rem_q - BEAT_LEN;
      load_base = base_q + BASE_STEP;
    end
  end

  assign load_rem_x = {1'b0, load_rem};
  assign beat_last  = (load_rem_x <= BEAT_BYTES);

  genvar gi;
  for (gi = 0; gi < TDATA_BYTES; gi++) begin : g_lane
    assign beat_keep[gi]        = (load_rem_x > (LENGTH_WIDTH+1)'(gi));
    assign beat_data[gi*8 +: 8] = beat_keep[gi] ? (load_base + 8'(gi)) : 8'h00;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    base_d   = base_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tdest_d  = tdest_q;
    tuser_d  = tuser_q;
    tid_d    = tid_q;
    busy_d   = busy_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && (cmd_length != '0)) begin
          state_d = SEND;
          busy_d  = 1'b1;
          tdest_d = cmd_tdest;
          tuser_d = cmd_tuser;
          tid_d   = cmd_tid;
        end
      end
      SEND: begin
        if (tvalid_q && tx.tx_tready && tlast_q) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          count_d  = count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      rem_d    = load_rem;
      base_d   = load_base;
      tvalid_d = 1'b1;
      tlast_d  = beat_last;
      tdata_d  = beat_data;
      tkeep_d  = beat_keep;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      base_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tdest_q  <= '0;
      tuser_q  <= '0;
      tid_q    <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      base_q   <= base_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tdest_q  <= tdest_d;
      tuser_q  <= tuser_d;
      tid_q    <= tid_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  // Gated by areset_n so no command is offered while reset is held.
  assign cmd_ready    = areset_n && (state_q == IDLE);

  assign tx.tx_tvalid = tvalid_q;
  assign tx.tx_tlast  = tlast_q;
  assign tx.tx_tdata  = tdata_q;
  assign tx.tx_tkeep  = tkeep_q;
  assign tx.tx_tstrb  = tkeep_q;
  assign tx.tx_tdest  = tdest_q;
  assign tx.tx_tuser  = tuser_q;
  assign tx.tx_tid    = tid_q;
  assign busy         = busy_q;
  assign packet_count = count_q;
endmodule

// File: tb/tb_logic_axi4_stream_packet_generator.sv
// Directed bench for the AXI4-Stream packet generator (4-byte beats, 16-bit length).
// The cases cover the partial last beat, seed wrap, zero length, stalls, reset mid-packet and maximum length.
module tb_logic_axi4_stream_packet_generator;
  localparam int TB = 4;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_seed;
  logic [0:0]  cmd_tdest, cmd_tid, cmd_tuser;
  logic        busy;
  logic [31:0] packet_count;

  int tests  = 0;
  int failed = 0;

  logic_axi4_stream_packet_generator_if #(
    .TDATA_BYTES(TB), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1)
  ) tx_if ();

  logic_axi4_stream_packet_generator #(
    .TDATA_BYTES(TB), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1), .LENGTH_WIDTH(16)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
    .cmd_seed(cmd_seed), .cmd_tdest(cmd_tdest), .cmd_tid(cmd_tid), .cmd_tuser(cmd_tuser),
    .tx(tx_if), .busy(busy), .packet_count(packet_count)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte k = seed + k in beat k/4, lane k%4. Unused lanes are 0.
  task automatic exp_beat(input int len, input logic [7:0] seed, input int b,
                          output logic [31:0] d, output logic [3:0] k, output logic l);
    d = '0;
    k = '0;
    for (int i = 0; i < TB; i++) begin
      int idx;
      idx = b * TB + i;
      if (idx < len) begin
        d[i*8 +: 8] = seed + 8'(idx);
        k[i] = 1'b1;
      end
    end
    l = ((b + 1) * TB >= len);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    check({tag, " tvalid"}, 64'(tx_if.tx_tvalid), 64'(1'b1));
    check({tag, " tdata"},  64'(tx_if.tx_tdata),  64'(d));
    check({tag, " tkeep"},  64'(tx_if.tx_tkeep),  64'(k));
    check({tag, " tstrb"},  64'(tx_if.tx_tstrb),  64'(k));
    check({tag, " tlast"},  64'(tx_if.tx_tlast),  64'(l));
  endtask

  task automatic send_cmd(input int len, input logic [7:0] seed, input logic dest, input logic id, input logic user);
    check("cmd_ready before accept", 64'(cmd_ready), 64'(1'b1));
    cmd_length = 16'(len);
    cmd_seed   = seed;
    cmd_tdest  = dest;
    cmd_tid    = id;
    cmd_tuser  = user;
    cmd_valid  = 1'b1;
    @(negedge aclk);
    cmd_valid  = 1'b0;
  endtask

  // The receiver is called at the negedge where beat 0 should already be valid.
  // tx_tready is chosen at each negedge and is sampled at the following posedge.
  task automatic recv_packet(input string name, input int len, input logic [7:0] seed,
                             input logic dest, input logic id, input logic user, input bit rand_ready);
    int beats;
    int b;
    int cyc;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    beats = (len + TB - 1) / TB;
    b = 0;
    cyc = 0;
    while (b < beats && cyc < beats * 4 + 20) begin
      exp_beat(len, seed, b, d, k, l);
      expect_beat($sformatf("%s b%0d", name, b), d, k, l);
      check($sformatf("%s b%0d tdest", name, b), 64'(tx_if.tx_tdest), 64'(dest));
      check($sformatf("%s b%0d tid", name, b),   64'(tx_if.tx_tid),   64'(id));
      check($sformatf("%s b%0d tuser", name, b), 64'(tx_if.tx_tuser), 64'(user));
      check($sformatf("%s b%0d cmd_ready", name, b), 64'(cmd_ready), 64'(1'b0));
      check($sformatf("%s b%0d busy", name, b), 64'(busy), 64'(1'b1));
      tx_if.tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_if.tx_tvalid && tx_if.tx_tready) b++;
      @(negedge aclk);
      cyc++;
    end
    check({name, " beats delivered"}, 64'(b), 64'(beats));
  endtask

  task automatic expect_idle(input string tag, input logic [31:0] count);
    check({tag, " tvalid"},       64'(tx_if.tx_tvalid), 64'(1'b0));
    check({tag, " cmd_ready"},    64'(cmd_ready),       64'(1'b1));
    check({tag, " busy"},         64'(busy),            64'(1'b0));
    check({tag, " packet_count"}, 64'(packet_count),    64'(count));
  endtask

  initial begin
    areset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_length = '0;
    cmd_seed = '0;
    cmd_tdest = '0;
    cmd_tid = '0;
    cmd_tuser = '0;
    tx_if.tx_tready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    check("reset tvalid",       64'(tx_if.tx_tvalid), 64'(1'b0));
    check("reset cmd_ready",    64'(cmd_ready),       64'(1'b0));
    check("reset busy",         64'(busy),            64'(1'b0));
    check("reset packet_count", 64'(packet_count),    64'(0));
    areset_n = 1'b1;
    @(negedge aclk);
    check("post reset cmd_ready", 64'(cmd_ready), 64'(1'b1));

    // Length 10, seed 0: two full beats, then a 2-byte tail.
    tx_if.tx_tready = 1'b1;
    send_cmd(10, 8'h00, 1'b1, 1'b0, 1'b1);
    expect_beat("len10 b0", 32'h03020100, 4'hF, 1'b0);
    check("len10 tdest", 64'(tx_if.tx_tdest), 64'(1'b1));
    check("len10 tid",   64'(tx_if.tx_tid),   64'(1'b0));
    check("len10 tuser", 64'(tx_if.tx_tuser), 64'(1'b1));
    check("len10 cmd_ready", 64'(cmd_ready), 64'(1'b0));
    @(negedge aclk);
    expect_beat("len10 b1", 32'h07060504, 4'hF, 1'b0);
    @(negedge aclk);
    expect_beat("len10 b2", 32'h00000908, 4'h3, 1'b1);
    @(negedge aclk);
    expect_idle("len10 done", 32'd1);

    // Length 8, seed 0xFE: the seed wraps through 0xFF to 0x00.
    send_cmd(8, 8'hFE, 1'b0, 1'b1, 1'b0);
    expect_beat("len8 b0", 32'h0100FFFE, 4'hF, 1'b0);
    @(negedge aclk);
    expect_beat("len8 b1", 32'h05040302, 4'hF, 1'b1);
    @(negedge aclk);
    expect_idle("len8 done", 32'd2);

    // A zero-length command is dropped. A length-1 command then sends one byte.
    send_cmd(0, 8'h33, 1'b1, 1'b1, 1'b1);
    expect_idle("len0", 32'd2);
    @(negedge aclk);
    expect_idle("len0 later", 32'd2);
    send_cmd(1, 8'h5A, 1'b0, 1'b0, 1'b0);
    expect_beat("len1 b0", 32'h0000005A, 4'h1, 1'b1);
    @(negedge aclk);
    expect_idle("len1 done", 32'd3);

    // Length 100 with random stalls and cmd_valid held high.
    // The second copy must start exactly two cycles after the last handshake.
    check("len100 cmd_ready", 64'(cmd_ready), 64'(1'b1));
    cmd_length = 16'd100;
    cmd_seed   = 8'h37;
    cmd_tdest  = 1'b1;
    cmd_tid    = 1'b0;
    cmd_tuser  = 1'b1;
    cmd_valid  = 1'b1;
    @(negedge aclk);
    recv_packet("len100a", 100, 8'h37, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_idle("len100a gap", 32'd4);
    @(negedge aclk);
    cmd_valid = 1'b0;
    recv_packet("len100b", 100, 8'h37, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_idle("len100b done", 32'd5);

    // Reset while beat 3 of a 64-byte packet is on the bus.
    tx_if.tx_tready = 1'b1;
    send_cmd(64, 8'h10, 1'b1, 1'b1, 1'b1);
    expect_beat("len64 b0", 32'h13121110, 4'hF, 1'b0);
    @(negedge aclk);
    @(negedge aclk);
    @(negedge aclk);
    expect_beat("len64 b3", 32'h1F1E1D1C, 4'hF, 1'b0);
    areset_n = 1'b0;
    @(negedge aclk);
    check("midrst tvalid", 64'(tx_if.tx_tvalid), 64'(1'b0));
    check("midrst tlast",  64'(tx_if.tx_tlast),  64'(1'b0));
    check("midrst tdata",  64'(tx_if.tx_tdata),  64'(0));
    check("midrst tkeep",  64'(tx_if.tx_tkeep),  64'(0));
    check("midrst tstrb",  64'(tx_if.tx_tstrb),  64'(0));
    check("midrst tdest",  64'(tx_if.tx_tdest),  64'(0));
    check("midrst tid",    64'(tx_if.tx_tid),    64'(0));
    check("midrst tuser",  64'(tx_if.tx_tuser),  64'(0));
    check("midrst packet_count", 64'(packet_count), 64'(0));
    check("midrst busy",      64'(busy),      64'(1'b0));
    check("midrst cmd_ready", 64'(cmd_ready), 64'(1'b0));
    @(negedge aclk);
    check("midrst held cmd_ready", 64'(cmd_ready), 64'(1'b0));
    areset_n = 1'b1;
    @(negedge aclk);
    expect_idle("midrst release", 32'd0);
    check("midrst release tlast", 64'(tx_if.tx_tlast), 64'(1'b0));
    send_cmd(4, 8'hA0, 1'b0, 1'b1, 1'b0);
    expect_beat("len4 b0", 32'hA3A2A1A0, 4'hF, 1'b1);
    @(negedge aclk);
    expect_idle("len4 done", 32'd1);

    // Maximum length 65535: 16384 beats, and the final beat keeps 3 bytes.
    send_cmd(65535, 8'h00, 1'b1, 1'b0, 1'b0);
    recv_packet("len65535", 65535, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_idle("len65535 done", 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
